cy_slavefifo_port: RTL and testbench

- Cypress FX2 async slave-FIFO port engine on sys_clk (50 MHz); the only block that toggles SLRD/SLWR/SLOE/FIFOADR/PKTEND.
- Drains the FX2 EP2 OUT FIFO into a one-byte valid/ready stream consumed by the UART/MCU command logic.
- Pushes a valid/ready byte stream from that logic into the EP6 IN FIFO, committing short packets with PKTEND.
- Sits directly between the FX2 pins and the command/SDRAM logic.

---
 rtl/cy_slavefifo_port.sv | 238 +++++++++++++++++++++++
 tb/tb_cy_slavefifo_port.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cy_slavefifo_port.sv
// FX2 asynchronous slave-FIFO engine: drains EP2 OUT into the rx stream, pushes the tx stream to EP6 IN.
// Define CY_AUTO_PKTEND_EN to commit a partial EP6 packet after PKT_TIMEOUT idle cycles.
module cy_slavefifo_port #(
    parameter int unsigned STROBE_CYC  = 3,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned PKT_TIMEOUT = 50000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] cy_fd_in,
    output logic [7:0] cy_fd_out,
    output logic       cy_fd_oe,
    input  logic       cy_flaga,
    input  logic       cy_flagb,
    output logic       cy_slrd,
    output logic       cy_slwr,
    output logic       cy_sloe,
    output logic [1:0] cy_fifoadr,
    output logic       cy_pktend,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready
);
    localparam int unsigned CntMax = (STROBE_CYC > SETTLE_CYC) ? STROBE_CYC : SETTLE_CYC;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StRdSetup,
        StRdStb,
        StRdSettle,
        StWrSetup,
        StWrStb,
        StWrHold,
        StPktStb,
        StWrSettle
    } state_t;

    state_t            r_state;
    logic [CntW-1:0]   r_cnt;
    logic              r_prio_wr;
    logic              r_last;
    logic [1:0]        r_flaga_sync;
    logic [1:0]        r_flagb_sync;
    logic              r_slrd;
    logic              r_slwr;
    logic              r_sloe;
    logic              r_pktend;
    logic              r_fd_oe;
    logic [7:0]        r_fd_out;
    logic [1:0]        r_fifoadr;
    logic [7:0]        r_rx_data;
    logic              r_rx_valid;
    logic              r_tx_ready;

    logic w_rd_elig;
    logic w_wr_elig;
    logic w_strobe_done;
    logic w_settle_done;
    logic w_auto_fire;

    // Flags reset to "empty"/"full" so nothing starts before the synchronizers fill.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_flaga_sync <= 2'b00;
            r_flagb_sync <= 2'b00;
        end else begin
            r_flaga_sync <= {r_flaga_sync[0], cy_flaga};
            r_flagb_sync <= {r_flagb_sync[0], cy_flagb};
        end
    end

    assign w_rd_elig     = r_flaga_sync[1] & ~r_rx_valid;
    assign w_wr_elig     = r_flagb_sync[1] & tx_valid;
    assign w_strobe_done = (r_cnt == CntW'(STROBE_CYC - 1));
    assign w_settle_done = (r_cnt == CntW'(SETTLE_CYC - 1));

`ifdef CY_AUTO_PKTEND_EN
    logic [15:0] r_idle_cnt;
    logic        r_pend;

    // Armed by a write without tx_last; only IDLE cycles advance the timer.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_idle_cnt <= '0;
            r_pend     <= 1'b0;
        end else if (r_state == StWrSetup) begin
            r_pend     <= ~r_last;
            r_idle_cnt <= '0;
        end else if (w_auto_fire) begin
            r_pend <= 1'b0;
        end else if (r_state == StIdle && r_pend && r_idle_cnt < 16'(PKT_TIMEOUT)) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    assign w_auto_fire = (r_state == StIdle) && r_pend &&
                         (r_idle_cnt >= 16'(PKT_TIMEOUT)) && !tx_valid;
`else
    logic w_unused_timeout;
    assign w_auto_fire      = 1'b0;
    assign w_unused_timeout = ^PKT_TIMEOUT;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_prio_wr  <= 1'b0;
            r_last     <= 1'b0;
            r_slrd     <= 1'b1;
            r_slwr     <= 1'b1;
            r_sloe     <= 1'b1;
            r_pktend   <= 1'b1;
            r_fd_oe    <= 1'b0;
            r_fd_out   <= '0;
            r_fifoadr  <= 2'b00;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
        end else begin
            r_tx_ready <= 1'b0;
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (w_auto_fire) begin
                        r_state   <= StPktStb;
                        r_fifoadr <= 2'b10;
                        r_pktend  <= 1'b0;
                    end else if (w_rd_elig && (!w_wr_elig || !r_prio_wr)) begin
                        r_state   <= StRdSetup;
                        r_fifoadr <= 2'b00;
                        r_sloe    <= 1'b0;
                        r_prio_wr <= 1'b1;
                    end else if (w_wr_elig) begin
                        r_state    <= StWrSetup;
                        r_fifoadr  <= 2'b10;
                        r_fd_oe    <= 1'b1;
                        r_fd_out   <= tx_data;
                        r_last     <= tx_last;
                        r_tx_ready <= 1'b1;
                        r_prio_wr  <= 1'b0;
                    end
                end
                StRdSetup: begin
                    r_state <= StRdStb;
                    r_slrd  <= 1'b0;
                    r_cnt   <= '0;
                end
                StRdStb: begin
                    if (w_strobe_done) begin
                        r_state    <= StRdSettle;
                        r_slrd     <= 1'b1;
                        r_rx_data  <= cy_fd_in;
                        r_rx_valid <= 1'b1;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StRdSettle: begin
                    // FX2 keeps driving FD for one cycle past the strobe.
                    r_sloe <= 1'b1;
                    if (w_settle_done) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWrSetup: begin
                    r_state <= StWrStb;
                    r_slwr  <= 1'b0;
                    r_cnt   <= '0;
                end
                StWrStb: begin
                    if (w_strobe_done) begin
                        r_state <= StWrHold;
                        r_slwr  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWrHold: begin
                    r_fd_oe <= 1'b0;
                    r_cnt   <= '0;
                    if (r_last) begin
                        r_state  <= StPktStb;
                        r_pktend <= 1'b0;
                    end else begin
                        r_state <= StWrSettle;
                    end
                end
                StPktStb: begin
                    if (w_strobe_done) begin
                        r_state  <= StWrSettle;
                        r_pktend <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StWrSettle: begin
                    if (w_settle_done) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign cy_fd_out  = r_fd_out;
    assign cy_fd_oe   = r_fd_oe;
    assign cy_slrd    = r_slrd;
    assign cy_slwr    = r_slwr;
    assign cy_sloe    = r_sloe;
    assign cy_fifoadr = r_fifoadr;
    assign cy_pktend  = r_pktend;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign tx_ready   = r_tx_ready;

endmodule

// File: tb/tb_cy_slavefifo_port.sv
// Directed bench for cy_slavefifo_port with an EP2 FIFO model and rx/tx scoreboards.
// Define CY_AUTO_PKTEND_EN to exercise the automatic PKTEND timeout (PKT_TIMEOUT = 100).
module tb_cy_slavefifo_port;
    localparam int unsigned StrobeCyc = 3;
    localparam int unsigned SettleCyc = 4;
`ifdef CY_AUTO_PKTEND_EN
    localparam int unsigned PktTimeout = 100;
`else
    localparam int unsigned PktTimeout = 50000;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] cy_fd_in = 8'h00;
    logic [7:0] cy_fd_out;
    logic       cy_fd_oe;
    logic       cy_flaga = 1'b0;
    logic       cy_flagb = 1'b1;
    logic       cy_slrd;
    logic       cy_slwr;
    logic       cy_sloe;
    logic [1:0] cy_fifoadr;
    logic       cy_pktend;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;

    cy_slavefifo_port #(
        .STROBE_CYC (StrobeCyc),
        .SETTLE_CYC (SettleCyc),
        .PKT_TIMEOUT(PktTimeout)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cy_fd_in  (cy_fd_in),
        .cy_fd_out (cy_fd_out),
        .cy_fd_oe  (cy_fd_oe),
        .cy_flaga  (cy_flaga),
        .cy_flagb  (cy_flagb),
        .cy_slrd   (cy_slrd),
        .cy_slwr   (cy_slwr),
        .cy_sloe   (cy_sloe),
        .cy_fifoadr(cy_fifoadr),
        .cy_pktend (cy_pktend),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #10 sys_clk = ~sys_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards, EP2 FIFO contents and event log
    logic [7:0] ep2_q[$];
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    logic [7:0] ev_log[$];

    int   cyc = 0;
    int   n_rd = 0, n_wr = 0, n_pk = 0, n_txr = 0;
    int   w_rd = 0, w_wr = 0, w_pk = 0, w_tr = 0;
    int   last_rd_fall = 0, last_pk_fall = 0;
    bit   have_rd = 1'b0;
    logic p_slrd = 1'b1, p_slwr = 1'b1, p_pk = 1'b1, p_tr = 1'b0;

    always @(negedge sys_clk) begin
        logic [7:0] e;
        cyc++;
        if (sys_rst) begin
            p_slrd = 1'b1; p_slwr = 1'b1; p_pk = 1'b1; p_tr = 1'b0;
            w_rd = 0; w_wr = 0; w_pk = 0; w_tr = 0;
            have_rd = 1'b0;
            ep2_q.delete(); rx_exp.delete(); tx_exp.delete(); ev_log.delete();
        end else begin
            chk("bus_dir", 32'(cy_fd_oe & ~cy_sloe), 32'd0);
            if (p_slrd && !cy_slrd) begin
                chk("rd_sloe", 32'(cy_sloe), 32'd0);
                chk("rd_adr", 32'(cy_fifoadr), 32'd0);
                if (have_rd) chk("rd_gap_ge8", 32'((cyc - last_rd_fall) >= 8), 32'd1);
                have_rd = 1'b1; last_rd_fall = cyc; n_rd++; w_rd = 1;
                ev_log.push_back(8'h52);
            end else if (!cy_slrd) begin
                w_rd++;
            end else if (!p_slrd) begin
                chk("rd_width", 32'(w_rd), StrobeCyc);
            end
            if (p_slwr && !cy_slwr) begin
                n_wr++; w_wr = 1;
                ev_log.push_back(8'h57);
                chk("wr_adr", 32'(cy_fifoadr), 32'd2);
                chk("wr_oe", 32'(cy_fd_oe), 32'd1);
                chk("wr_q_nonempty", 32'(tx_exp.size() != 0), 32'd1);
                if (tx_exp.size() != 0) begin
                    e = tx_exp.pop_front();
                    chk("wr_data", 32'(cy_fd_out), 32'(e));
                end
            end else if (!cy_slwr) begin
                w_wr++;
            end else if (!p_slwr) begin
                chk("wr_width", 32'(w_wr), StrobeCyc);
                chk("wr_hold_oe", 32'(cy_fd_oe), 32'd1);
            end
            if (p_pk && !cy_pktend) begin
                n_pk++; last_pk_fall = cyc; w_pk = 1;
                chk("pk_adr", 32'(cy_fifoadr), 32'd2);
                chk("pk_oe", 32'(cy_fd_oe), 32'd0);
            end else if (!cy_pktend) begin
                w_pk++;
            end else if (!p_pk) begin
                chk("pk_width", 32'(w_pk), StrobeCyc);
            end
            if (tx_ready) begin
                if (!p_tr) begin
                    n_txr++; w_tr = 0;
                end
                w_tr++;
            end else if (p_tr) begin
                chk("txr_width", 32'(w_tr), 32'd1);
            end
            if (rx_valid && rx_ready) begin
                chk("rx_q_nonempty", 32'(rx_exp.size() != 0), 32'd1);
                if (rx_exp.size() != 0) begin
                    e = rx_exp.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e));
                end
            end
            // EP2 model: a completed read strobe consumes the head byte
            if (!p_slrd && cy_slrd && ep2_q.size() != 0) void'(ep2_q.pop_front());
            p_slrd = cy_slrd; p_slwr = cy_slwr; p_pk = cy_pktend; p_tr = tx_ready;
        end
        cy_flaga = (ep2_q.size() != 0);
        cy_fd_in = (ep2_q.size() != 0) ? ep2_q[0] : 8'h00;
    end

    task automatic push_rd(input logic [7:0] d);
        ep2_q.push_back(d);
        rx_exp.push_back(d);
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int k = 0;
        while ((ep2_q.size() != 0 || rx_exp.size() != 0) && k < bound) begin
            @(negedge sys_clk);
            k++;
        end
        chk(tag, 32'(k < bound), 32'd1);
    endtask

    task automatic send_tx(input logic [7:0] d, input logic l, input bit hold, input string tag);
        int k = 0;
        @(posedge sys_clk); #1;
        tx_data = d; tx_last = l; tx_valid = 1'b1;
        tx_exp.push_back(d);
        do begin
            @(negedge sys_clk);
            k++;
        end while (!tx_ready && k < 100);
        chk(tag, 32'(tx_ready), 32'd1);
        @(posedge sys_clk); #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    initial begin
        #(20 * 20000);
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_rd, b_wr, b_pk, b_tr, k, t0;

        @(negedge sys_clk);
        chk("rst_slrd", 32'(cy_slrd), 32'd1);
        chk("rst_slwr", 32'(cy_slwr), 32'd1);
        chk("rst_sloe", 32'(cy_sloe), 32'd1);
        chk("rst_pktend", 32'(cy_pktend), 32'd1);
        chk("rst_fd_oe", 32'(cy_fd_oe), 32'd0);
        chk("rst_fd_out", 32'(cy_fd_out), 32'd0);
        chk("rst_fifoadr", 32'(cy_fifoadr), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        @(posedge sys_clk); #1 sys_rst = 1'b0;

        // Streaming reads, several data patterns, consumer always ready
        b_rd = n_rd;
        rx_ready = 1'b1;
        push_rd(8'hA5); push_rd(8'h5A); push_rd(8'hC3);
        wait_drain("rd_stream_timeout", 100);
        repeat (20) @(negedge sys_clk);
        chk("rd_stream_count", 32'(n_rd - b_rd), 32'd3);

        // Back-pressure: one read only, data held until accepted
        @(posedge sys_clk); #1 rx_ready = 1'b0;
        b_rd = n_rd;
        push_rd(8'hA5); push_rd(8'hA5);
        repeat (20) @(negedge sys_clk);
        chk("bp_one_read", 32'(n_rd - b_rd), 32'd1);
        chk("bp_rx_valid", 32'(rx_valid), 32'd1);
        chk("bp_rx_data", 32'(rx_data), 32'hA5);
        @(posedge sys_clk); #1 rx_ready = 1'b1;
        wait_drain("bp_drain_timeout", 100);
        repeat (10) @(negedge sys_clk);
        chk("bp_two_reads", 32'(n_rd - b_rd), 32'd2);

        // Single write with tx_last: slwr then pktend
        b_wr = n_wr; b_pk = n_pk; b_tr = n_txr;
        send_tx(8'h3C, 1'b1, 1'b0, "wr_last_accept");
        k = 0;
        while (n_pk == b_pk && k < 40) begin
            @(negedge sys_clk);
            k++;
        end
        repeat (10) @(negedge sys_clk);
        chk("wr_last_slwr", 32'(n_wr - b_wr), 32'd1);
        chk("wr_last_pktend", 32'(n_pk - b_pk), 32'd1);
        chk("wr_last_txready", 32'(n_txr - b_tr), 32'd1);

        // EP6 full blocks the write; release starts it promptly
        @(posedge sys_clk); #1 cy_flagb = 1'b0;
        repeat (3) @(negedge sys_clk);
        b_wr = n_wr; b_tr = n_txr; b_pk = n_pk;
        @(posedge sys_clk); #1;
        tx_data = 8'h81; tx_last = 1'b0; tx_valid = 1'b1;
        tx_exp.push_back(8'h81);
        repeat (20) @(negedge sys_clk);
        chk("full_no_slwr", 32'(n_wr - b_wr), 32'd0);
        chk("full_no_txready", 32'(n_txr - b_tr), 32'd0);
        @(posedge sys_clk); #1 cy_flagb = 1'b1;
        k = 0;
        do begin
            @(negedge sys_clk);
            k++;
        end while (!tx_ready && k < 10);
        chk("full_release_le4", 32'(tx_ready && k <= 4), 32'd1);
        t0 = cyc;
        @(posedge sys_clk); #1 tx_valid = 1'b0;
        repeat (150) @(negedge sys_clk);
        chk("full_write_done", 32'(n_wr - b_wr), 32'd1);
`ifdef CY_AUTO_PKTEND_EN
        chk("auto_pktend_count", 32'(n_pk - b_pk), 32'd1);
        chk("auto_pktend_window", 32'((last_pk_fall - t0) >= 100 && (last_pk_fall - t0) <= 125), 32'd1);
`else
        chk("no_auto_pktend", 32'(n_pk - b_pk), 32'd0);
`endif

        // Simultaneous read/write demand from a fresh reset: strict alternation
        @(posedge sys_clk); #1 cy_flagb = 1'b0;
        pulse_reset();
        repeat (3) @(negedge sys_clk);
        @(posedge sys_clk); #1;
        cy_flagb = 1'b1;
        push_rd(8'hB1); push_rd(8'h4E);
        send_tx(8'hD1, 1'b0, 1'b1, "mix_tx0_accept");
        send_tx(8'h2D, 1'b0, 1'b0, "mix_tx1_accept");
        wait_drain("mix_drain_timeout", 100);
        repeat (30) @(negedge sys_clk);
        chk("mix_events", 32'(ev_log.size()), 32'd4);
        if (ev_log.size() == 4) begin
            chk("mix_order0", 32'(ev_log[0]), 32'h52);
            chk("mix_order1", 32'(ev_log[1]), 32'h57);
            chk("mix_order2", 32'(ev_log[2]), 32'h52);
            chk("mix_order3", 32'(ev_log[3]), 32'h57);
        end

        // Reset during the read strobe: strobes released at once, byte dropped
        push_rd(8'hE7);
        k = 0;
        do begin
            @(negedge sys_clk);
            k++;
        end while (cy_slrd && k < 20);
        chk("rst_mid_reached_stb", 32'(cy_slrd), 32'd0);
        #3 sys_rst = 1'b1;
        #1;
        chk("rst_mid_slrd", 32'(cy_slrd), 32'd1);
        chk("rst_mid_sloe", 32'(cy_sloe), 32'd1);
        chk("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        b_rd = n_rd;
        repeat (20) @(negedge sys_clk);
        chk("rst_mid_no_read", 32'(n_rd - b_rd), 32'd0);
        chk("rst_mid_dropped", 32'(rx_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
